// File: rtl/seg_readback.sv
// Decodes a scanned active-low 7-seg bus back into a 32-bit hex frame; optional SEG_READBACK_DP_EN adds dp_mask.
// Latency: frame valid one cycle after the final digit is accepted; min frame 8*STABLE_CNT cycles.
// Backpressure: frame, err and dp_mask held (scan input ignored) until out_valid && out_ready.
module seg_readback #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  dig_idx,
  input  logic        scan_valid,
  output logic [31:0] number,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
`ifdef SEG_READBACK_DP_EN
  ,
  output logic [7:0]  dp_mask
`endif
);

  typedef enum logic [0:0] {COLLECT, DONE} state_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

  state_t      state_q;
  logic [10:0] prev_q;
  logic        prev_vld_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] nib_q, nib_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] number_q;
  logic        out_valid_q;
  logic        err_q;
  logic [10:0] pair;
  logic        same;
  logic        accept;
  logic [3:0]  dec_nib;
  logic        dec_bad;
`ifdef SEG_READBACK_DP_EN
  logic [7:0]  dp_q, dp_d;
  logic [7:0]  dp_mask_q;
`endif

  // Active-high segments a..g, MSB first; blank decodes to 0 without flagging.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      7'h00:   r = 5'h00;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    pair = {dig_idx, seg_in};
    same = prev_vld_q && (pair == prev_q);
    {dec_bad, dec_nib} = decode(~seg_in[7:1]);

    if (!scan_valid)          cnt_d = 8'd0;
    else if (!same)           cnt_d = 8'd1;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;

    // Fire only on the transition into CNT_MAX, not while saturated on the same pair.
    accept = (state_q == COLLECT) && scan_valid && (cnt_d == CNT_MAX) &&
             !(same && (cnt_q == CNT_MAX));

    nib_d = nib_q;
    nib_d[{dig_idx, 2'b00} +: 4] = dec_nib;
    mask_d = mask_q | (8'b1 << dig_idx);
`ifdef SEG_READBACK_DP_EN
    dp_d = dp_q;
    dp_d[dig_idx] = ~seg_in[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      cnt_q       <= '0;
      nib_q       <= '0;
      mask_q      <= '0;
      number_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef SEG_READBACK_DP_EN
      dp_q        <= '0;
      dp_mask_q   <= '0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          prev_q     <= pair;
          prev_vld_q <= scan_valid;
          cnt_q      <= cnt_d;
          if (accept) begin
            nib_q  <= nib_d;
            mask_q <= mask_d;
            if (dec_bad) err_q <= 1'b1;
`ifdef SEG_READBACK_DP_EN
            dp_q <= dp_d;
`endif
            if (mask_d == 8'hFF) begin
              number_q    <= nib_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
`ifdef SEG_READBACK_DP_EN
              dp_mask_q   <= dp_d;
`endif
            end
          end
        end
        DONE: begin
          // Clear history so the next frame's first sample starts a fresh count.
          cnt_q      <= '0;
          prev_vld_q <= 1'b0;
          if (out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            mask_q      <= '0;
            state_q     <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign number    = number_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
`ifdef SEG_READBACK_DP_EN
  assign dp_mask   = dp_mask_q;
`endif

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback (STABLE_CNT=4): frame table plus glitch, backpressure and reset sequences.
module tb_seg_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [2:0]  dig_idx;
  logic        scan_valid;
  logic [31:0] number;
  logic        out_valid;
  logic        out_ready;
  logic        err;
`ifdef SEG_READBACK_DP_EN
  logic [7:0]  dp_mask;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_readback #(.STABLE_CNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dig_idx    (dig_idx),
    .scan_valid (scan_valid),
    .number     (number),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
`ifdef SEG_READBACK_DP_EN
    ,
    .dp_mask    (dp_mask)
`endif
  );

  typedef logic [7:0][7:0] segs_t;
  typedef struct {
    segs_t       segs;
    logic [31:0] num;
    logic        e;
    logic [7:0]  dp;
  } frame_t;

  frame_t tbl [3];

  // Active-low bus byte for a hex digit, dp off.
  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h7E; 4'h1: p = 7'h30; 4'h2: p = 7'h6D; 4'h3: p = 7'h79;
      4'h4: p = 7'h33; 4'h5: p = 7'h5B; 4'h6: p = 7'h5F; 4'h7: p = 7'h70;
      4'h8: p = 7'h7F; 4'h9: p = 7'h7B; 4'hA: p = 7'h77; 4'hB: p = 7'h1F;
      4'hC: p = 7'h4E; 4'hD: p = 7'h3D; 4'hE: p = 7'h4F; default: p = 7'h47;
    endcase
    return {~p, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] i, input logic [7:0] s, input int n);
    scan_valid = v;
    dig_idx    = i;
    seg_in     = s;
    repeat (n) tick();
  endtask

  task automatic send_frame(input segs_t segs, input string nm);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), segs[k], 4);
      if (k < 7) chk({nm, " early valid"}, {31'b0, out_valid}, 32'd0);
    end
    scan_valid = 1'b0;
  endtask

  task automatic handshake(input string nm, input logic [31:0] keep);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " valid after hs"}, {31'b0, out_valid}, 32'd0);
    chk({nm, " err after hs"}, {31'b0, err}, 32'd0);
    chk({nm, " number kept"}, number, keep);
  endtask

  initial begin
    segs_t s;

    rst = 1'b0; scan_valid = 1'b0; dig_idx = 3'd0; seg_in = 8'hFF; out_ready = 1'b0;
    repeat (2) tick();
    chk("reset number", number, 32'd0);
    chk("reset valid", {31'b0, out_valid}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
`ifdef SEG_READBACK_DP_EN
    chk("reset dp_mask", {24'b0, dp_mask}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    // 8,7,...,1 with slot 3 dp lit
    for (int k = 0; k < 8; k++) s[k] = enc(4'(8 - k));
    s[3][0] = 1'b0;
    tbl[0] = '{segs: s, num: 32'h12345678, e: 1'b0, dp: 8'h08};
    // slot 0 undecodable (active-high 2A), rest 9..F
    s[0] = 8'hAB;
    for (int k = 1; k < 8; k++) s[k] = enc(4'(k + 8));
    tbl[1] = '{segs: s, num: 32'hFEDCBA90, e: 1'b1, dp: 8'h00};
    // 0..6 then blank in slot 7
    for (int k = 0; k < 7; k++) s[k] = enc(4'(k));
    s[7] = 8'hFF;
    tbl[2] = '{segs: s, num: 32'h06543210, e: 1'b0, dp: 8'h00};

    for (int t = 0; t < 3; t++) begin
      string nm;
      nm = $sformatf("frame%0d", t);
      send_frame(tbl[t].segs, nm);
      chk({nm, " valid"}, {31'b0, out_valid}, 32'd1);
      chk({nm, " number"}, number, tbl[t].num);
      chk({nm, " err"}, {31'b0, err}, {31'b0, tbl[t].e});
`ifdef SEG_READBACK_DP_EN
      chk({nm, " dp_mask"}, {24'b0, dp_mask}, {24'b0, tbl[t].dp});
`endif
      handshake(nm, tbl[t].num);
    end

    // Glitch: slot 2 shows 5 for 3 cycles, then E long enough to accept.
    drive(1'b1, 3'd0, enc(4'h0), 4);
    drive(1'b1, 3'd1, enc(4'h1), 4);
    drive(1'b1, 3'd2, enc(4'h5), 3);
    drive(1'b1, 3'd2, enc(4'hE), 4);
    for (int k = 3; k < 8; k++) begin
      drive(1'b1, 3'(k), enc(4'(k)), 4);
      if (k < 7) chk("glitch early valid", {31'b0, out_valid}, 32'd0);
    end
    scan_valid = 1'b0;
    chk("glitch valid", {31'b0, out_valid}, 32'd1);
    chk("glitch number", number, 32'h76543E10);

    // Backpressure: scan keeps changing while out_ready is low.
    drive(1'b1, 3'd0, enc(4'hF), 5);
    drive(1'b1, 3'd1, enc(4'hC), 5);
    chk("bp number held", number, 32'h76543E10);
    chk("bp valid held", {31'b0, out_valid}, 32'd1);
    chk("bp err held", {31'b0, err}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 3'd2, enc(4'hD), 1);
    out_ready = 1'b0;
    scan_valid = 1'b0;
    chk("bp valid dropped", {31'b0, out_valid}, 32'd0);
    chk("bp number kept", number, 32'h76543E10);
    tick();

    // Reset after 5 digits (one undecodable) discards the partial frame.
    drive(1'b1, 3'd0, enc(4'h3), 4);
    drive(1'b1, 3'd1, 8'hAB, 4);
    for (int k = 2; k < 5; k++) drive(1'b1, 3'(k), enc(4'h7), 4);
    scan_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("midrst number", number, 32'd0);
    chk("midrst valid", {31'b0, out_valid}, 32'd0);
    chk("midrst err", {31'b0, err}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) s[k] = enc(4'(k + 10));
    send_frame(s, "post-reset");
    chk("post-reset valid", {31'b0, out_valid}, 32'd1);
    chk("post-reset number", number, 32'h10FEDCBA);
    chk("post-reset err", {31'b0, err}, 32'd0);
`ifdef SEG_READBACK_DP_EN
    chk("post-reset dp_mask", {24'b0, dp_mask}, 32'd0);
`endif
    handshake("post-reset", 32'h10FEDCBA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_readback.md
Name: seg_readback

Overview:
- Reverse path of the 8-digit hex seven-segment display driver: watches a scanned, active-low segment bus (one digit per scan slot) and decodes each pattern back into its hex nibble.
- Filters glitches with a stability counter and assembles all 8 digits into a 32-bit frame.
- Presents the frame to a consumer with a valid/ready handshake.
- Used as an on-board self-check and readback monitor for the display subsystem.

Parameters:
- STABLE_CNT, 4, consecutive identical cycles required to accept a digit sample. Legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- seg_in  input  8  active-low segment pattern; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- dig_idx  input  3  digit slot of seg_in; 0 = least-significant nibble
- scan_valid  input  1  seg_in/dig_idx meaningful this cycle
- number  output  32  assembled frame; digit k occupies bits [4k+3:4k]
- out_valid  output  1  frame complete and held
- out_ready  input  1  consumer accepts frame
- err  output  1  at least one undecodable pattern accepted in this frame

Behaviour:
- Reset: rst==0 sampled at a clk edge clears number, out_valid, err, the capture mask, the nibble registers and the stability counter. The FSM goes to COLLECT. Reset mid-frame discards partial data.
- Decode works on the active-high segments p = ~seg_in[7:1], ordered a..g, MSB first. dp is ignored.
- Decode table: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
  - 00 (blank) → 0, not an error.
  - Any other value → nibble 0 and the invalid flag is set.
- Stability filter, COLLECT state only:
  - A tracked sample is the pair {dig_idx, seg_in}.
  - With scan_valid=1 and the pair equal to the previous cycle's pair, the counter increments and saturates at STABLE_CNT.
  - A different pair or scan_valid=0 reloads the counter to 1 (pair differs, valid) or 0 (not valid).
  - Acceptance fires exactly once, on the cycle the counter reaches STABLE_CNT. Further identical cycles do not re-accept until the pair changes.
  - With STABLE_CNT=1, every new valid pair accepts immediately.
- On acceptance:
  - The nibble is written to slot dig_idx and mask[dig_idx] is set.
  - An invalid pattern sets err, which is sticky for the frame.
  - Re-accepting an already-captured slot overwrites its nibble. The mask is unchanged.
- FSM:
  - COLLECT→DONE: on the edge where the acceptance makes mask==8'hFF. number, err and out_valid=1 update on that same edge.
  - DONE: number and err are held stable. The scan input is ignored and the counter is held at 0.
  - DONE→COLLECT: on an edge with out_valid && out_ready. out_valid, err and mask clear on that edge, and that cycle's scan input is ignored. number keeps its last value.
- out_ready while in COLLECT has no effect.
- Latency: final digit accepted → out_valid high at the next cycle. Minimum frame time is 8*STABLE_CNT cycles.

Optional Feature:
- Macro SEG_READBACK_DP_EN.
- Defined:
  - Extra output dp_mask [7:0]. Bit k = ~seg_in[0] captured when digit k is accepted.
  - dp_mask has the same hold/clear rules as number: it holds in DONE and keeps its value after handshake.
  - dp_mask resets to 0.
- Undefined: the port is absent and dp is fully ignored.

Test Plan:
- Reset, then digits 0..7 = patterns for 8,7,6,5,4,3,2,1, each held 4 cycles with scan_valid → out_valid=1, number=32'h12345678, err=0, the cycle after the 32nd sample.
- Slot 2 shows 5B for 3 cycles, then 4F for 4 cycles (STABLE_CNT=4) → nibble 2 = E; the 5B glitch is never captured.
- Full frame with slot 0 = 0x55 (active-high pattern 2A) → out_valid=1, err=1, number[3:0]=0. The next frame (all valid) gives err=0.
- Frame complete with out_ready held low for 10 cycles while the scan input keeps changing → number unchanged. out_ready=1 for one cycle → out_valid=0 next cycle.
- rst=0 for one cycle after 5 digits captured → all outputs 0. Re-sending all 8 digits (A,b,C,d,E,F,0,1, slot 0 first) yields number=32'h10FEDCBA.
- With SEG_READBACK_DP_EN: slot 3 dp low (seg_in[0]=0) → dp_mask=8'h08 with the frame.
